// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Purpose  : Multiply/divide unit with HI/LO result registers. Multiply-class
//            ops hold busy for MUL_CYCLES and divide-class ops for DIV_CYCLES.
//            The result is computed at the accepting edge and committed to
//            HI/LO on the edge where busy falls.
// Options  : MDU_MADD_EN - enables madd/maddu/msub/msubu (opcodes 7..10).
//            When undefined, those opcodes behave as "none".
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDUop,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // Opcode encodings
  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mthi  = 4'd5;
  localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] c_op_madd  = 4'd7;
  localparam logic [3:0] c_op_maddu = 4'd8;
  localparam logic [3:0] c_op_msub  = 4'd9;
  localparam logic [3:0] c_op_msubu = 4'd10;
`endif

  // Busy durations, legal range 1..255 so 8 bits suffice
  localparam logic [7:0] c_mul_n = MUL_CYCLES[7:0];
  localparam logic [7:0] c_div_n = DIV_CYCLES[7:0];

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [7:0]       cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             wr_q,     wr_d;

  // --------------------------------------------------------------------------
  // Products: sign/zero extend to 2*WIDTH so the truncated product is exact
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_ext_a_s;
  logic [2*WIDTH-1:0] w_ext_b_s;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;

  assign w_ext_a_s = {{WIDTH{srcA[WIDTH-1]}}, srcA};
  assign w_ext_b_s = {{WIDTH{srcB[WIDTH-1]}}, srcB};
  assign w_prod_s  = w_ext_a_s * w_ext_b_s;
  assign w_prod_u  = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};

  // --------------------------------------------------------------------------
  // Division: signed ops divide magnitudes and fix signs afterwards. This also
  // yields most-negative / -1 = most-negative with remainder 0 naturally.
  // A zero divisor is replaced by 1 only to keep the datapath defined; the
  // result is never committed in that case.
  // --------------------------------------------------------------------------
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_sdiv_b;
  logic [WIDTH-1:0] w_sq;
  logic [WIDTH-1:0] w_sr;
  logic [WIDTH-1:0] w_q_s;
  logic [WIDTH-1:0] w_r_s;
  logic [WIDTH-1:0] w_udiv_b;
  logic [WIDTH-1:0] w_q_u;
  logic [WIDTH-1:0] w_r_u;

  assign w_a_neg  = srcA[WIDTH-1];
  assign w_b_neg  = srcB[WIDTH-1];
  assign w_b_zero = (srcB == '0);
  assign w_mag_a  = w_a_neg ? (~srcA + c_one) : srcA;
  assign w_mag_b  = w_b_neg ? (~srcB + c_one) : srcB;
  assign w_sdiv_b = w_b_zero ? c_one : w_mag_b;
  assign w_sq     = w_mag_a / w_sdiv_b;
  assign w_sr     = w_mag_a % w_sdiv_b;
  assign w_q_s    = (w_a_neg ^ w_b_neg) ? (~w_sq + c_one) : w_sq;
  assign w_r_s    = w_a_neg ? (~w_sr + c_one) : w_sr;
  assign w_udiv_b = w_b_zero ? c_one : srcB;
  assign w_q_u    = srcA / w_udiv_b;
  assign w_r_u    = srcA % w_udiv_b;

`ifdef MDU_MADD_EN
  // Accumulate paths operate on the current {HI,LO}, modulo 2^(2*WIDTH)
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_madd_s;
  logic [2*WIDTH-1:0] w_madd_u;
  logic [2*WIDTH-1:0] w_msub_s;
  logic [2*WIDTH-1:0] w_msub_u;

  assign w_acc    = {hi_q, lo_q};
  assign w_madd_s = w_acc + w_prod_s;
  assign w_madd_u = w_acc + w_prod_u;
  assign w_msub_s = w_acc - w_prod_s;
  assign w_msub_u = w_acc - w_prod_u;
`endif

  // Next-state logic: accept in IDLE, count down in BUSY, commit on exit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (MDUop)
            c_op_mult: begin
              {res_hi_d, res_lo_d} = w_prod_s;
              wr_d    = 1'b1;
              cnt_d   = c_mul_n;
              state_d = ST_BUSY;
            end
            c_op_multu: begin
              {res_hi_d, res_lo_d} = w_prod_u;
              wr_d    = 1'b1;
              cnt_d   = c_mul_n;
              state_d = ST_BUSY;
            end
            c_op_div: begin
              res_hi_d = w_r_s;
              res_lo_d = w_q_s;
              wr_d     = ~w_b_zero;
              cnt_d    = c_div_n;
              state_d  = ST_BUSY;
            end
            c_op_divu: begin
              res_hi_d = w_r_u;
              res_lo_d = w_q_u;
              wr_d     = ~w_b_zero;
              cnt_d    = c_div_n;
              state_d  = ST_BUSY;
            end
            c_op_mthi: hi_d = srcA;
            c_op_mtlo: lo_d = srcA;
`ifdef MDU_MADD_EN
            c_op_madd: begin
              {res_hi_d, res_lo_d} = w_madd_s;
              wr_d    = 1'b1;
              cnt_d   = c_mul_n;
              state_d = ST_BUSY;
            end
            c_op_maddu: begin
              {res_hi_d, res_lo_d} = w_madd_u;
              wr_d    = 1'b1;
              cnt_d   = c_mul_n;
              state_d = ST_BUSY;
            end
            c_op_msub: begin
              {res_hi_d, res_lo_d} = w_msub_s;
              wr_d    = 1'b1;
              cnt_d   = c_mul_n;
              state_d = ST_BUSY;
            end
            c_op_msubu: begin
              {res_hi_d, res_lo_d} = w_msub_u;
              wr_d    = 1'b1;
              cnt_d   = c_mul_n;
              state_d = ST_BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // start is ignored here; the counter alone decides when to finish
        if (cnt_q <= 8'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          wr_d    = 1'b0;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        wr_d    = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_BUSY);
  end

  // State and result registers; reset discards any pending result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu
// Purpose  : Scoreboard bench for e_mdu. Stimulus computes expected HI/LO and
//            busy length from arithmetic rules and queues them; a monitor pops
//            and compares whenever an op completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu;

  localparam int W    = 32;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    MDUop = 4'd0;
  logic [W-1:0]  srcA  = '0;
  logic [W-1:0]  srcB  = '0;
  logic          busy;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  e_mdu #(.WIDTH(W), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUop (MDUop),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;

  // monitor-owned state
  logic [W-1:0]  e_hi = '0;
  logic [W-1:0]  e_lo = '0;
  int            bcnt = 0;
  exp_t          it;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: counts busy cycles, pops an expectation on completion, and
  // checks HI/LO against the last committed expectation on every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      e_hi = '0;
      e_lo = '0;
      bcnt = 0;
    end else begin
      if (busy) begin
        bcnt++;
      end else if (sb.size() > 0 && (sb[0].lat == bcnt || bcnt > 0)) begin
        it = sb.pop_front();
        chk("busy_len", 32'(bcnt), 32'(it.lat));
        e_hi = it.hi;
        e_lo = it.lo;
        bcnt = 0;
      end else if (bcnt > 0) begin
        chk("unexpected_busy", 32'(bcnt), 32'd0);
        bcnt = 0;
      end
      chk("hi", HI, e_hi);
      chk("lo", LO, e_lo);
    end
  end

  // Drive one request, compute its architectural effect, queue expectation
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ps, pu, acc, r;
    longint         sa, sbv, q, rm;
    logic [W-1:0]   nh, nl;
    int             lat;
    exp_t           e;
    nh  = m_hi;
    nl  = m_lo;
    lat = 0;
    ps  = 64'(longint'($signed(a)) * longint'($signed(b)));
    pu  = {32'd0, a} * {32'd0, b};
    acc = {m_hi, m_lo};
    r   = '0;
    case (op)
      4'd1: begin r = ps; nh = r[2*W-1:W]; nl = r[W-1:0]; lat = MULN; end
      4'd2: begin r = pu; nh = r[2*W-1:W]; nl = r[W-1:0]; lat = MULN; end
      4'd3: begin
        lat = DIVN;
        if (b != 0) begin
          sa  = longint'($signed(a));
          sbv = longint'($signed(b));
          q   = sa / sbv;
          rm  = sa % sbv;
          nl  = 32'(q);
          nh  = 32'(rm);
        end
      end
      4'd4: begin
        lat = DIVN;
        if (b != 0) begin
          nl = a / b;
          nh = a % b;
        end
      end
      4'd5: nh = a;
      4'd6: nl = a;
`ifdef MDU_MADD_EN
      4'd7:  begin r = acc + ps; nh = r[2*W-1:W]; nl = r[W-1:0]; lat = MULN; end
      4'd8:  begin r = acc + pu; nh = r[2*W-1:W]; nl = r[W-1:0]; lat = MULN; end
      4'd9:  begin r = acc - ps; nh = r[2*W-1:W]; nl = r[W-1:0]; lat = MULN; end
      4'd10: begin r = acc - pu; nh = r[2*W-1:W]; nl = r[W-1:0]; lat = MULN; end
`endif
      default: ;
    endcase
    @(negedge clk);
    start = 1'b1;
    MDUop = op;
    srcA  = a;
    srcB  = b;
    @(posedge clk);
    #1;
    e.hi  = nh;
    e.lo  = nl;
    e.lat = lat;
    sb.push_back(e);
    m_hi  = nh;
    m_lo  = nl;
    start = 1'b0;
    MDUop = 4'($urandom_range(0, 15));
    srcA  = $urandom;
    srcB  = $urandom;
  endtask

  // Wait (bounded) for busy to drop; optionally fire ignored starts meanwhile
  task automatic wait_idle(input bit inject);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (inject && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        MDUop = 4'($urandom_range(0, 15));
        srcA  = $urandom;
        srcB  = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] lo_before;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // mult -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // div -7 / 2, divu 7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    issue(4'd4, 32'd7, 32'd2);
    wait_idle(0);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // mthi then divide by zero, then signed overflow
    issue(4'd5, 32'h1234, 32'd0);
    wait_idle(0);
    lo_before = LO;
    issue(4'd4, 32'd99, 32'd0);
    wait_idle(0);
    chk("dz_hi", HI, 32'h1234);
    chk("dz_lo", LO, lo_before);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(0);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);

    // multu with an ignored mtlo during busy
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    MDUop = 4'd6;
    srcA  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle(0);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);

    // reset in cycle 3 of a div: immediate clear, nothing written later
    issue(4'd5, 32'hAAAA, 32'd0);
    wait_idle(0);
    issue(4'd6, 32'h5555, 32'd0);
    wait_idle(0);
    issue(4'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

    // first request after reset
    issue(4'd4, 32'd7, 32'd2);
    wait_idle(0);
    chk("after_rst_lo", LO, 32'd3);

    // accumulate vector
    issue(4'd5, 32'd0, 32'd0);
    wait_idle(0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    wait_idle(0);
    issue(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    chk("maddu_busy", {31'd0, busy}, 32'd1);
    wait_idle(0);
    chk("maddu_hi", HI, 32'd1);
    chk("maddu_lo", LO, 32'd0);
`else
    chk("maddu_busy", {31'd0, busy}, 32'd0);
    wait_idle(0);
    chk("maddu_hi", HI, 32'd0);
    chk("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

    // randomized traffic with ignored starts during busy
    for (int n = 0; n < 150; n++) begin
      issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val());
      wait_idle(1);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
